// File: rtl/mult_div.sv
// mult_div: execute-stage HI/LO unit with iterative multiply/divide; define FAST_MULT_EN for a single-cycle multiplier
module mult_div #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              en,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] operand_1,
  input  logic [DATA_W-1:0] operand_2,
  output logic              stall_request,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam int CW = $clog2(DATA_W);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] opb_q, opb_d, hi_q, hi_d, lo_q, lo_d;
  logic neg_a_q, neg_a_d, neg_r_q, neg_r_d, wb_q, wb_d, div_q, div_d;
  logic idle, is_mul, is_div, sgn, s1, s2;
  logic [DATA_W-1:0] mag1, mag2;
  logic [DATA_W:0] mul_sum, div_top, div_sub;
  logic div_ge;
`ifdef FAST_MULT_EN
  logic [2*DATA_W-1:0] fast_raw, fast_prod;
`endif
  // operand decode, magnitudes and one iteration step of each datapath
  always_comb begin
    idle = state_q == IDLE;
    is_mul = (funct == F_MULT) || (funct == F_MULTU);
    is_div = (funct == F_DIV) || (funct == F_DIVU);
    sgn = (funct == F_MULT) || (funct == F_DIV);
    s1 = sgn & operand_1[DATA_W-1];
    s2 = sgn & operand_2[DATA_W-1];
    mag1 = s1 ? -operand_1 : operand_1;
    mag2 = s2 ? -operand_2 : operand_2;
    mul_sum = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    div_top = acc_q[2*DATA_W-1:DATA_W-1];
    div_sub = div_top - {1'b0, opb_q};
    div_ge = div_top >= {1'b0, opb_q};
`ifdef FAST_MULT_EN
    fast_raw = mag1 * mag2;
    fast_prod = (s1 ^ s2) ? -fast_raw : fast_raw;
`endif
  end
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      opb_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      neg_a_q <= 1'b0;
      neg_r_q <= 1'b0;
      wb_q <= 1'b0;
      div_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      opb_q <= opb_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      neg_a_q <= neg_a_d;
      neg_r_q <= neg_r_d;
      wb_q <= wb_d;
      div_q <= div_d;
    end
  end
  // next state: issue, iterate, and sign-corrected HI/LO writeback in DONE
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    opb_d = opb_q;
    hi_d = hi_q;
    lo_d = lo_q;
    neg_a_d = neg_a_q;
    neg_r_d = neg_r_q;
    wb_d = wb_q;
    div_d = div_q;
    if (flush) begin
      state_d = IDLE;
      cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: if (en) begin
          if (funct == F_MTHI) hi_d = operand_1;
          if (funct == F_MTLO) lo_d = operand_1;
`ifdef FAST_MULT_EN
          if (is_mul) {hi_d, lo_d} = fast_prod;
`else
          if (is_mul) begin
            state_d = MUL;
            cnt_d = '0;
            acc_d = {{DATA_W{1'b0}}, mag2};
            opb_d = mag1;
            neg_a_d = s1 ^ s2;
            wb_d = 1'b1;
            div_d = 1'b0;
          end
`endif
          if (is_div) begin
            state_d = (|operand_2) ? DIV : DONE;
            cnt_d = '0;
            acc_d = {{DATA_W{1'b0}}, mag1};
            opb_d = mag2;
            neg_a_d = s1 ^ s2;
            neg_r_d = s1;
            wb_d = |operand_2;
            div_d = 1'b1;
          end
        end
        MUL: begin
          acc_d = {mul_sum, acc_q[DATA_W-1:1]};
          cnt_d = cnt_q + 1'b1;
          state_d = (cnt_q == CW'(DATA_W-1)) ? DONE : MUL;
        end
        DIV: begin
          acc_d = {div_ge ? div_sub[DATA_W-1:0] : div_top[DATA_W-1:0], acc_q[DATA_W-2:0], div_ge};
          cnt_d = cnt_q + 1'b1;
          state_d = (cnt_q == CW'(DATA_W-1)) ? DONE : DIV;
        end
        DONE: begin
          state_d = IDLE;
          if (wb_q && !div_q) {hi_d, lo_d} = neg_a_q ? -acc_q : acc_q;
          if (wb_q && div_q) begin
            lo_d = neg_a_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
            hi_d = neg_r_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];
          end
        end
      endcase
    end
  end
  // outputs: stall while an op is issuing or iterating, MFHI/MFLO read port
  always_comb begin
`ifdef FAST_MULT_EN
    stall_request = ~flush & ((state_q == MUL) | (state_q == DIV) | (idle & en & is_div));
`else
    stall_request = ~flush & ((state_q == MUL) | (state_q == DIV) | (idle & en & (is_div | is_mul)));
`endif
    result = (idle & en & (funct == F_MFHI)) ? hi_q :
             (idle & en & (funct == F_MFLO)) ? lo_q : '0;
    hi = hi_q;
    lo = lo_q;
  end
endmodule

// File: doc/mult_div.md
Name: mult_div

Overview:
- Execute-stage HI/LO unit. It consumes the 6-bit FUNCT code produced in ID for SPECIAL-opcode instructions.
- Performs MULT/MULTU iteratively (32 cycles) and DIV/DIVU iteratively (32 cycles, restoring division).
- Owns the HI/LO architectural registers and serves MFHI/MFLO/MTHI/MTLO.
- Raises a stall request to the pipeline controller while an operation is in flight.

Parameters:
- DATA_W, 32, operand/HI/LO width. The iteration count equals DATA_W.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- flush  in  1  synchronous pipeline flush; abandons any in-flight op
- en  in  1  valid instruction present in EX
- funct  in  6  FUNCT code from ID (SPECIAL encodings)
- operand_1  in  32  rs value (multiplicand / dividend)
- operand_2  in  32  rt value (multiplier / divisor)
- stall_request  out  1  hold PC/IF/ID/EX while high
- result  out  32  MFHI/MFLO read data for EX writeback path
- hi  out  32  current HI register
- lo  out  32  current LO register

Behaviour:
- FUNCT codes handled: MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13, MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B. Any other funct: no action, result = 0.
- Reset (rst=1 at edge): state IDLE, hi=0, lo=0, counter=0, internal shift registers = 0. stall_request=0 the cycle after reset.
- States: IDLE, MUL, DIV, DONE.
- IDLE, en=1, funct MULT/MULTU: latch magnitudes (signed: two's-complement abs; unsigned: raw) and neg_prod = (op1[31]^op2[31]) & signed. Next state MUL, counter=0. stall_request=1 combinationally in this issue cycle.
- IDLE, en=1, funct DIV/DIVU with operand_2 != 0: latch magnitudes, neg_q = sign1^sign2, neg_r = sign1 (signed only). Next state DIV, stall_request=1.
- IDLE, en=1, DIV/DIVU with operand_2 == 0: go directly to DONE; HI/LO left unchanged. Stall is asserted only in the issue cycle.
- MUL: shift-add one multiplier bit per cycle into a 64-bit accumulator. counter increments; when counter==DATA_W-1, go to DONE. stall_request=1.
- DIV: restoring division on a 64-bit remainder/quotient register, one bit per cycle, same counter rule. stall_request=1.
- DONE: stall_request=0 so the pipeline advances. At this edge, HI/LO are written with sign-corrected results and the state returns to IDLE. en/funct in DONE are ignored: this is the same instruction.
- Result mapping:
  - MUL: {hi,lo} = neg_prod ? -acc : acc.
  - DIV: lo = neg_q ? -quot : quot; hi = neg_r ? -rem : rem.
  - 0x80000000 / 0xFFFFFFFF (signed) gives lo=0x80000000, hi=0.
- Latency: issue cycle plus 32 busy cycles gives 33 stalled cycles. New HI/LO are visible the cycle after DONE. An MFHI immediately behind a MULT therefore reads the new value.
- MTHI/MTLO in IDLE with en=1: write operand_1 to hi/lo at the edge, no stall.
- MFHI/MFLO: result = hi/lo combinationally (registered value). result = 0 when en=0.
- While in MUL/DIV, en/funct/operands are ignored; latched copies are used.
- flush=1 at any edge: state to IDLE, counter to 0, HI/LO unchanged, no write from DONE. stall_request = busy & ~flush.
- rst has priority over flush; flush has priority over new issue.

Optional Feature:
- Macro FAST_MULT_EN.
- Defined: MULT/MULTU compute a single-cycle 64-bit product in the issue cycle (no stall) and write HI/LO at that edge. DIV/DIVU behaviour is unchanged.
- Undefined: the iterative 32-cycle multiply described above.

Test Plan:
- MULT op1=0xFFFFFFFD (-3), op2=7 -> stall_request high exactly 33 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFEB. Under FAST_MULT_EN: 0 stall cycles, same values.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Then MFHI issued next -> result=0xFFFFFFFE.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 5/0 with hi=0x11, lo=0x22 preset via MTHI/MTLO -> stall only in the issue cycle; hi=0x11, lo=0x22 unchanged.
- MULT 6*7 issued; flush asserted in busy cycle 10 -> stall drops that cycle, state IDLE, HI/LO unchanged. A following MULTU 2*3 gives lo=6, hi=0.
- DIV in flight; rst asserted at busy cycle 5 -> next cycle hi=lo=0 and stall_request=0. A following MTLO 0xABCD then MFLO -> result=0xABCD.
